cam_capture: RTL and testbench

- Capture front end between the OV7670-style camera pins and the frame-buffer memory.
- Samples pclk, href, vsync and data in the system clock domain and packs each two-byte RGB565 pixel into one RGB332 byte.
- Issues one write per pixel (mem_we, mem_addr, mem_data) toward the frame buffer.
- wb_camera starts a capture with capture_start and watches busy, done, pixel_count and frame_err.

---
 rtl/cam_capture_if.sv | 28 ++
 rtl/cam_capture.sv | 142 ++++++++++++++
 tb/tb_cam_capture.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_if.sv
// Camera pins, capture control/status and frame-buffer write port of cam_capture.
// The slave side belongs to the capture block and the master side to whoever drives the camera.
interface cam_capture_if #(
  parameter int ADDR_WIDTH = 19
);
  logic                  pclk;
  logic                  vsync;
  logic                  href;
  logic [7:0]            data;
  logic                  capture_start;
  logic                  busy;
  logic                  done;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_data;
  logic [ADDR_WIDTH-1:0] pixel_count;
  logic                  frame_err;

  modport slave (
    input  pclk, vsync, href, data, capture_start,
    output busy, done, mem_we, mem_addr, mem_data, pixel_count, frame_err
  );

  modport master (
    output pclk, vsync, href, data, capture_start,
    input  busy, done, mem_we, mem_addr, mem_data, pixel_count, frame_err
  );
endinterface

// File: rtl/cam_capture.sv
// OV7670-style capture front end: synchronizes the camera bus into clk and packs
// RGB565 byte pairs into RGB332 frame-buffer writes, one full frame per start.
module cam_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic          clk,
  input  logic          rst,
  cam_capture_if.slave  cam
);

  localparam logic [ADDR_WIDTH:0] TOTAL = (ADDR_WIDTH+1)'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE, DONE} state_e;

  state_e                state_q;
  logic                  pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic                  href_s1_q, href_s2_q, href_s3_q;
  logic                  vsync_s1_q, vsync_s2_q, vsync_s3_q;
  logic [7:0]            data_s1_q, data_s2_q;
  logic                  phase_q;
  logic [5:0]            b0_q;
  logic                  busy_q, done_q, mem_we_q, frame_err_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q, pixel_count_q;
  logic [7:0]            mem_data_q;

  logic                  pclk_rise, href_fall, vsync_rise, vsync_fall;
  logic                  full, wr_fire;
  logic [ADDR_WIDTH:0]   cnt_after_d;

  assign pclk_rise  = pclk_s2_q & ~pclk_s3_q;
  assign href_fall  = ~href_s2_q & href_s3_q;
  assign vsync_rise = vsync_s2_q & ~vsync_s3_q;
  assign vsync_fall = ~vsync_s2_q & vsync_s3_q;
  assign full       = ({1'b0, pixel_count_q} == TOTAL);

  // Count as it will stand after this cycle, so a pixel landing with vsync rise is included.
  assign wr_fire     = (state_q == ACTIVE) & pclk_rise & href_s2_q & phase_q & ~full;
  assign cnt_after_d = {1'b0, pixel_count_q} + (ADDR_WIDTH+1)'(wr_fire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pclk_s1_q     <= 1'b0;
      pclk_s2_q     <= 1'b0;
      pclk_s3_q     <= 1'b0;
      href_s1_q     <= 1'b0;
      href_s2_q     <= 1'b0;
      href_s3_q     <= 1'b0;
      vsync_s1_q    <= 1'b0;
      vsync_s2_q    <= 1'b0;
      vsync_s3_q    <= 1'b0;
      data_s1_q     <= '0;
      data_s2_q     <= '0;
      phase_q       <= 1'b0;
      b0_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      pixel_count_q <= '0;
    end else begin
      pclk_s1_q  <= cam.pclk;
      pclk_s2_q  <= pclk_s1_q;
      pclk_s3_q  <= pclk_s2_q;
      href_s1_q  <= cam.href;
      href_s2_q  <= href_s1_q;
      href_s3_q  <= href_s2_q;
      vsync_s1_q <= cam.vsync;
      vsync_s2_q <= vsync_s1_q;
      vsync_s3_q <= vsync_s2_q;
      data_s1_q  <= cam.data;
      data_s2_q  <= data_s1_q;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cam.capture_start) begin
            frame_err_q   <= 1'b0;
            pixel_count_q <= '0;
            mem_addr_q    <= '0;
            phase_q       <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= WAIT_FRAME;
          end
        end

        // Only a vsync fall marks a frame we saw from its first line.
        WAIT_FRAME: begin
          if (vsync_fall) state_q <= ACTIVE;
        end

        ACTIVE: begin
          if (pclk_rise && href_s2_q) begin
            if (!phase_q) begin
              b0_q    <= {data_s2_q[7:5], data_s2_q[2:0]};
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (full) begin
                frame_err_q <= 1'b1;
              end else begin
                mem_we_q      <= 1'b1;
                mem_addr_q    <= pixel_count_q;
                mem_data_q    <= {b0_q, data_s2_q[4:3]};
                pixel_count_q <= pixel_count_q + ADDR_WIDTH'(1);
              end
            end
          end else if (href_fall && phase_q) begin
            frame_err_q <= 1'b1;
            phase_q     <= 1'b0;
          end
          if (vsync_rise) begin
            if (cnt_after_d != TOTAL) frame_err_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cam.busy        = busy_q;
  assign cam.done        = done_q;
  assign cam.mem_we      = mem_we_q;
  assign cam.mem_addr    = mem_addr_q;
  assign cam.mem_data    = mem_data_q;
  assign cam.pixel_count = pixel_count_q;
  assign cam.frame_err   = frame_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture on a 4x2 frame: a byte-level camera model pushes expected
// writes into a queue that a negedge monitor pops against mem_we.
module tb_cam_capture;
  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 4;
  localparam int TOTAL = H * V;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  exp_t       q[$];
  bit         model_on;
  bit         m_phase;
  bit         m_err;
  int         m_cnt;
  logic [7:0] m_b0;

  cam_capture_if #(.ADDR_WIDTH(AW)) cam ();

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .cam (cam.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rgb332(input logic [7:0] b0, input logic [7:0] b1);
    return {b0[7:5], b0[2:0], b1[4:3]};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && cam.mem_we === 1'b1) begin
      exp_t e;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%0d data=%h", cam.mem_addr, cam.mem_data);
      end else begin
        e = q.pop_front();
        if (cam.mem_addr !== e.addr || cam.mem_data !== e.data) begin
          fails++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   cam.mem_addr, cam.mem_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit chk_lat);
    @(negedge clk);
    cam.data = b;
    @(negedge clk);
    @(negedge clk);
    if (model_on && cam.href) begin
      if (!m_phase) begin
        m_b0 = b;
        m_phase = 1'b1;
      end else begin
        m_phase = 1'b0;
        if (m_cnt < TOTAL) begin
          q.push_back('{AW'(m_cnt), rgb332(m_b0, b)});
          m_cnt++;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    cam.pclk = 1'b1;
    if (chk_lat) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      tests++;
      if (cam.mem_we !== 1'b0) begin
        fails++;
        $display("FAIL latency_early mem_we=%b want 0", cam.mem_we);
      end
      @(posedge clk);
      #1;
      tests++;
      if (cam.mem_we !== 1'b1) begin
        fails++;
        $display("FAIL latency mem_we=%b want 1", cam.mem_we);
      end
      @(negedge clk);
    end else begin
      @(negedge clk);
      @(negedge clk);
    end
    cam.pclk = 1'b0;
  endtask

  task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1, input int lat_idx);
    @(negedge clk);
    cam.href = 1'b1;
    for (int i = 0; i < n; i++) send_byte((i % 2) ? b1 : b0, i == lat_idx);
    @(negedge clk);
    @(negedge clk);
    cam.href = 1'b0;
    if (model_on && m_phase) begin
      m_err = 1'b1;
      m_phase = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    cam.vsync = 1'b1;
    repeat (6) @(negedge clk);
    cam.vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic start_cap(input string name);
    @(negedge clk);
    cam.capture_start = 1'b1;
    @(negedge clk);
    cam.capture_start = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    m_phase = 1'b0;
    model_on = 1'b1;
    tests++;
    if (cam.busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy busy=%b want 1", name, cam.busy);
    end
  endtask

  task automatic frame_end(input string name);
    bit seen;
    @(negedge clk);
    cam.vsync = 1'b1;
    if (m_cnt != TOTAL) m_err = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (cam.done === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_done no done pulse within 50 cycles", name);
    end
    tests++;
    if (cam.pixel_count !== AW'(m_cnt)) begin
      fails++;
      $display("FAIL %s_count pixel_count=%0d want %0d", name, cam.pixel_count, m_cnt);
    end
    tests++;
    if (cam.frame_err !== m_err) begin
      fails++;
      $display("FAIL %s_err frame_err=%b want %b", name, cam.frame_err, m_err);
    end
    @(negedge clk);
    tests++;
    if (cam.busy !== 1'b0 || cam.done !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle busy=%b done=%b want 0 0", name, cam.busy, cam.done);
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_pending %0d writes missing want 0", name, q.size());
      q.delete();
    end
    model_on = 1'b0;
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({cam.busy, cam.done, cam.mem_we, cam.frame_err} !== 4'b0 ||
        cam.mem_addr !== '0 || cam.mem_data !== '0 || cam.pixel_count !== '0) begin
      fails++;
      $display("FAIL %s busy=%b done=%b we=%b err=%b addr=%0d data=%h cnt=%0d want all 0",
               name, cam.busy, cam.done, cam.mem_we, cam.frame_err,
               cam.mem_addr, cam.mem_data, cam.pixel_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cam.pclk = 1'b0;
    cam.vsync = 1'b1;
    cam.href = 1'b0;
    cam.data = '0;
    cam.capture_start = 1'b0;
    model_on = 1'b0;
    #3;
    check_zero("reset_initial");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    // Mid-frame reset after a few pixels have been written.
    start_cap("reset");
    frame_start();
    @(negedge clk);
    cam.href = 1'b1;
    for (int i = 0; i < 5; i++) send_byte((i % 2) ? 8'h18 : 8'hE7, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_zero("reset_async");
    q.delete();
    model_on = 1'b0;
    cam.href = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // No capture_start: camera traffic must produce nothing.
    send_line(8, 8'hE7, 8'h18, -1);
    frame_start();
    send_line(8, 8'hE7, 8'h18, -1);
    check_zero("reset_no_start");
  endtask

  task automatic test_basic();
    start_cap("basic");
    frame_start();
    repeat (V) send_line(2 * H, 8'hE7, 8'h18, -1);
    frame_end("basic");
    tests++;
    if (cam.mem_data !== 8'hFF || cam.mem_addr !== AW'(7)) begin
      fails++;
      $display("FAIL basic_hold data=%h addr=%0d want ff 7", cam.mem_data, cam.mem_addr);
    end
  endtask

  task automatic test_mixed();
    start_cap("mixed");
    frame_start();
    send_line(2 * H, 8'hA5, 8'h3C, 1);
    send_line(2 * H, 8'hA5, 8'h3C, -1);
    frame_end("mixed");
    tests++;
    if (cam.mem_data !== 8'hB7) begin
      fails++;
      $display("FAIL mixed_data data=%h want b7", cam.mem_data);
    end
  endtask

  task automatic test_odd_line();
    start_cap("odd");
    frame_start();
    send_line(7, 8'hE7, 8'h18, -1);
    tests++;
    if (cam.frame_err !== 1'b1) begin
      fails++;
      $display("FAIL odd_err_after_href frame_err=%b want 1", cam.frame_err);
    end
    send_line(2 * H, 8'hA5, 8'h3C, -1);
    frame_end("odd");
  endtask

  task automatic test_line_count();
    start_cap("extra_line");
    frame_start();
    repeat (V + 1) send_line(2 * H, 8'h5A, 8'hC3, -1);
    frame_end("extra_line");
    start_cap("one_line");
    frame_start();
    send_line(2 * H, 8'h12, 8'h34, -1);
    frame_end("one_line");
  endtask

  task automatic test_back_to_back();
    // Start while busy must not restart or clear the count.
    start_cap("busy_start");
    frame_start();
    send_line(2 * H, 8'hE7, 8'h18, -1);
    @(negedge clk);
    cam.capture_start = 1'b1;
    @(negedge clk);
    cam.capture_start = 1'b0;
    tests++;
    if (cam.busy !== 1'b1 || cam.pixel_count !== AW'(H)) begin
      fails++;
      $display("FAIL busy_start_ignored busy=%b cnt=%0d want 1 %0d", cam.busy, cam.pixel_count, H);
    end
    send_line(2 * H, 8'hA5, 8'h3C, -1);
    frame_end("busy_start");
    // Start in the middle of a frame: that frame's tail is skipped.
    frame_start();
    send_line(2 * H, 8'hE7, 8'h18, -1);
    start_cap("midframe");
    model_on = 1'b0;
    send_line(2 * H, 8'hE7, 8'h18, -1);
    @(negedge clk);
    cam.vsync = 1'b1;
    repeat (8) @(negedge clk);
    tests++;
    if (cam.busy !== 1'b1 || cam.pixel_count !== '0 || cam.done !== 1'b0) begin
      fails++;
      $display("FAIL midframe_wait busy=%b cnt=%0d done=%b want 1 0 0",
               cam.busy, cam.pixel_count, cam.done);
    end
    model_on = 1'b1;
    frame_start();
    repeat (V) send_line(2 * H, 8'h81, 8'h7E, -1);
    frame_end("midframe");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_mixed();
    test_odd_line();
    test_line_count();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
